// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO family.
package fifo_pkg;

  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  // Occupancy needs one extra bit so that a full FIFO (count == depth) is representable.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/smemory_sync.sv
// Single-clock 1W/1R storage; read port is registered (standard) or asynchronous (FWFT).
module smemory_sync
  import fifo_pkg::*;
#(
  parameter int SIZE_DATA  = 8,
  parameter int SIZE_ADDR  = 4,
  parameter int SIZE_DEPTH = 16,
  parameter int FWFT       = FWFT_OFF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wr_en,
  input  logic [SIZE_ADDR-1:0] i_wr_addr,
  input  logic [SIZE_DATA-1:0] i_wr_data,
  input  logic                 i_rd_en,
  input  logic [SIZE_ADDR-1:0] i_rd_addr,
  output logic [SIZE_DATA-1:0] o_rd_data
);

  logic [SIZE_DATA-1:0] mem [SIZE_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
  end

  generate
    if (FWFT == FWFT_ON) begin : g_async_rd
      // i_rd_en acts as an output enable so an empty FIFO presents zero.
      assign o_rd_data = (i_rd_en && !i_rst) ? mem[i_rd_addr] : '0;
    end else begin : g_reg_rd
      // Non-blocking read returns the old entry on a same-address write.
      always_ff @(posedge i_clk) begin
        if (i_rst)        o_rd_data <= '0;
        else if (i_rd_en) o_rd_data <= mem[i_rd_addr];
      end
    end
  endgenerate

endmodule

// File: rtl/sync_fifo_param.sv
// Parameterised synchronous FIFO with occupancy flags, error pulses and optional FWFT read.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int SIZE_DATA  = 8,
  parameter int SIZE_ADDR  = 4,
  parameter int SIZE_DEPTH = 16,
  parameter int AFULL_TH   = 12,
  parameter int AEMPTY_TH  = 4,
  parameter int FWFT       = FWFT_OFF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wr_en,
  input  logic [SIZE_DATA-1:0] i_data_wr,
  input  logic                 i_rd_en,
  output logic [SIZE_DATA-1:0] o_data_rd,
  output logic                 o_valid,
  output logic                 o_full,
  output logic                 o_empty,
  output logic                 o_afull,
  output logic                 o_aempty,
  output logic [SIZE_ADDR:0]   o_count,
  output logic                 o_overflow,
  output logic                 o_underflow
);

  localparam int CNT_W = count_width(SIZE_DEPTH);

  logic [SIZE_ADDR-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 wr_acc, rd_acc, mem_rd_en;

  assign o_full   = (count == CNT_W'(SIZE_DEPTH));
  assign o_empty  = (count == '0);
  assign o_afull  = (count >= CNT_W'(AFULL_TH));
  assign o_aempty = (count <= CNT_W'(AEMPTY_TH));
  assign o_count  = count;

  assign wr_acc = i_wr_en && !o_full;
  assign rd_acc = i_rd_en && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      // Power-of-two depth makes natural pointer rollover the wrap.
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      o_overflow  <= i_wr_en && o_full;
      o_underflow <= i_rd_en && o_empty;
    end
  end

  assign mem_rd_en = (FWFT == FWFT_ON) ? !o_empty : rd_acc;

  smemory_sync #(
    .SIZE_DATA  (SIZE_DATA),
    .SIZE_ADDR  (SIZE_ADDR),
    .SIZE_DEPTH (SIZE_DEPTH),
    .FWFT       (FWFT)
  ) u_mem (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (wr_acc),
    .i_wr_addr (wr_ptr),
    .i_wr_data (i_data_wr),
    .i_rd_en   (mem_rd_en),
    .i_rd_addr (rd_ptr),
    .o_rd_data (o_data_rd)
  );

  generate
    if (FWFT == FWFT_ON) begin : g_vld_fwft
      assign o_valid = !o_empty;
    end else begin : g_vld_std
      // Read data register stage: valid tracks the word registered this cycle.
      logic rd_vld_p1;
      always_ff @(posedge i_clk) begin
        if (i_rst) rd_vld_p1 <= 1'b0;
        else       rd_vld_p1 <= rd_acc;
      end
      assign o_valid = rd_vld_p1;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: standard and FWFT instances share stimulus, checked against a queue model.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst, wr_en, rd_en;
  logic [7:0] data_wr;

  logic [7:0] std_data, fw_data;
  logic       std_valid, std_full, std_empty, std_afull, std_aempty, std_ovf, std_udf;
  logic       fw_valid, fw_full, fw_empty, fw_afull, fw_aempty, fw_ovf, fw_udf;
  logic [4:0] std_count, fw_count;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] q[$];
  logic [7:0] m_data;
  logic       m_valid, m_ovf, m_udf;

  always #5 clk = ~clk;

  sync_fifo_param #(.FWFT(0)) dut_std (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_data_wr(data_wr), .i_rd_en(rd_en),
    .o_data_rd(std_data), .o_valid(std_valid), .o_full(std_full), .o_empty(std_empty),
    .o_afull(std_afull), .o_aempty(std_aempty), .o_count(std_count),
    .o_overflow(std_ovf), .o_underflow(std_udf)
  );

  sync_fifo_param #(.FWFT(1)) dut_fw (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_data_wr(data_wr), .i_rd_en(rd_en),
    .o_data_rd(fw_data), .o_valid(fw_valid), .o_full(fw_full), .o_empty(fw_empty),
    .o_afull(fw_afull), .o_aempty(fw_aempty), .o_count(fw_count),
    .o_overflow(fw_ovf), .o_underflow(fw_udf)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Queue model: a FIFO is a list; push on accepted write, pop on accepted read.
  task automatic model_update(input logic wr, input logic [7:0] din, input logic rd, input logic rs);
    int  n;
    logic wok, rok;
    if (rs) begin
      q.delete();
      m_data = 8'h00; m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      n     = q.size();
      wok   = wr && (n < 16);
      rok   = rd && (n > 0);
      m_ovf = wr && (n == 16);
      m_udf = rd && (n == 0);
      m_valid = rok;
      if (rok) m_data = q.pop_front();
      if (wok) q.push_back(din);
    end
  endtask

  task automatic check_model();
    int n;
    n = q.size();
    chk("count",     std_count,  n);
    chk("full",      std_full,   n == 16);
    chk("empty",     std_empty,  n == 0);
    chk("afull",     std_afull,  n >= 12);
    chk("aempty",    std_aempty, n <= 4);
    chk("overflow",  std_ovf,    m_ovf);
    chk("underflow", std_udf,    m_udf);
    chk("std_data",  std_data,   m_data);
    chk("std_valid", std_valid,  m_valid);
    chk("fw_count",  fw_count,   n);
    chk("fw_full",   fw_full,    n == 16);
    chk("fw_empty",  fw_empty,   n == 0);
    chk("fw_ovf",    fw_ovf,     m_ovf);
    chk("fw_udf",    fw_udf,     m_udf);
    chk("fw_data",   fw_data,    (n > 0) ? q[0] : 8'h00);
    chk("fw_valid",  fw_valid,   n > 0);
  endtask

  task automatic step(input logic wr, input logic [7:0] din, input logic rd, input logic rs);
    @(negedge clk);
    wr_en = wr; data_wr = din; rd_en = rd; rst = rs;
    @(posedge clk);
    model_update(wr, din, rd, rs);
    #1;
    check_model();
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] din;
    logic       rd;
    logic       rs;
    int         cnt;
    logic       udf;
    logic [7:0] data;
    logic       valid;
  } vec_t;

  vec_t tbl[11];

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_wr = 8'h00;

    tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 8'h00, 1'b0};
    tbl[2]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1, 1'b1, 8'h00, 1'b0};
    tbl[3]  = '{1'b1, 8'h22, 1'b0, 1'b0, 2, 1'b0, 8'h00, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 8'h11, 1'b1};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b0, 8'h11, 1'b0};
    tbl[6]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1, 1'b0, 8'h22, 1'b1};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h33, 1'b1};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 8'h33, 1'b0};
    tbl[9]  = '{1'b1, 8'h44, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 8'h00, 1'b0};

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].wr, tbl[i].din, tbl[i].rd, tbl[i].rs);
      chk("tbl_count", std_count, tbl[i].cnt);
      chk("tbl_udf",   std_udf,   tbl[i].udf);
      chk("tbl_data",  std_data,  tbl[i].data);
      chk("tbl_valid", std_valid, tbl[i].valid);
    end

    // Fill 0x01..0x10, watching almost-full and full thresholds.
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 11) chk("afull_at11", std_afull, 1'b0);
      if (i == 12) chk("afull_at12", std_afull, 1'b1);
      if (i == 15) chk("full_at15",  std_full,  1'b0);
    end
    chk("fill_full",  std_full,  1'b1);
    chk("fill_count", std_count, 16);

    // Overflow while full: one-cycle pulse, 0xAA never stored.
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("ovf_pulse", std_ovf, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("ovf_clear", std_ovf, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("readback", std_data, i);
    end

    // Underflow while empty.
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("udf_pulse", std_udf, 1'b1);
    chk("udf_valid", std_valid, 1'b0);
    chk("udf_count", std_count, 0);

    // Simultaneous read+write at count 0, then at count 16.
    step(1'b1, 8'h60, 1'b1, 1'b0);
    chk("rw_empty_count", std_count, 1);
    for (int i = 0; i < 15; i++) step(1'b1, 8'h61 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    chk("rw_full_count", std_count, 15);
    chk("rw_full_ovf",   std_ovf,   1'b1);
    chk("rw_full_data",  std_data,  8'h60);

    // Drain to 8 then stream 40 read+write cycles through the pointer wrap.
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'($urandom), 1'b1, 1'b0);
      chk("wrap_count", std_count, 8);
    end

    // FWFT: write-to-visible latency of one, reset mid-stream clears output.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h5C, 1'b0, 1'b0);
    chk("fwft_5c",    fw_data,  8'h5C);
    chk("fwft_valid", fw_valid, 1'b1);
    step(1'b1, 8'h31, 1'b0, 1'b0);
    step(1'b1, 8'h32, 1'b0, 1'b1);
    chk("fwft_rst_empty", fw_empty, 1'b1);
    chk("fwft_rst_data",  fw_data,  8'h00);
    chk("std_rst_data",   std_data, 8'h00);
    step(1'b1, 8'h99, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_first", std_data, 8'h99);

    // Randomised traffic with shifting write/read bias and rare resets.
    for (int i = 0; i < 1500; i++) begin
      int wp, rp;
      wp = (i % 300 < 150) ? 70 : 35;
      rp = 100 - wp;
      step(($urandom % 100) < wp, 8'($urandom), ($urandom % 100) < rp, ($urandom % 200) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 SHALL provide parameter SIZE_DATA, default 8, width of one data word in bits.
REQ-002 SHALL provide parameter SIZE_ADDR, default 4, pointer width; depth is 2**SIZE_ADDR.
REQ-003 SHALL provide parameter SIZE_DEPTH, default 16, number of entries; it must equal 2**SIZE_ADDR.
REQ-004 SHALL provide parameter AFULL_TH, default 12, count at or above which o_afull is asserted.
REQ-005 SHALL provide parameter AEMPTY_TH, default 4, count at or below which o_aempty is asserted.
REQ-006 SHALL provide parameter FWFT, default 0, read mode: 0 is standard registered read, 1 is first-word-fall-through.
REQ-007 SHALL have one clock and a synchronous, active-high reset, with ports as follows.
REQ-008 SHALL provide port i_clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-009 SHALL provide port i_rst, input, 1 bit: synchronous active-high reset.
REQ-010 SHALL provide port i_wr_en, input, 1 bit: write request.
REQ-011 SHALL provide port i_data_wr, input, SIZE_DATA bits: write data.
REQ-012 SHALL provide port i_rd_en, input, 1 bit: read request (pop).
REQ-013 SHALL provide port o_data_rd, output, SIZE_DATA bits: read data.
REQ-014 SHALL provide port o_valid, output, 1 bit: o_data_rd holds a popped word (standard mode only).
REQ-015 SHALL provide port o_full, output, 1 bit: full flag.
REQ-016 SHALL provide port o_empty, output, 1 bit: empty flag.
REQ-017 SHALL provide port o_afull, output, 1 bit: almost-full flag.
REQ-018 SHALL provide port o_aempty, output, 1 bit: almost-empty flag.
REQ-019 SHALL provide port o_count, output, SIZE_ADDR+1 bits: current occupancy, 0 to SIZE_DEPTH.
REQ-020 SHALL provide port o_overflow, output, 1 bit: one-cycle pulse when a write is rejected.
REQ-021 SHALL provide port o_underflow, output, 1 bit: one-cycle pulse when a read is rejected.

Function
REQ-022 SHALL accept a write iff i_wr_en=1 and o_full=0; it stores i_data_wr at wr_ptr and wr_ptr advances by 1.
REQ-023 SHALL accept a read iff i_rd_en=1 and o_empty=0; rd_ptr advances by 1.
REQ-024 SHALL wrap both pointers modulo SIZE_DEPTH (from SIZE_DEPTH-1 to 0) with no bubble.
REQ-025 SHALL update o_count on the accepted-write and accepted-read events as follows.
- write only: +1
- read only: -1
- both: unchanged
- neither: unchanged
REQ-026 SHALL derive all flags from registered o_count: o_full=(count==SIZE_DEPTH), o_empty=(count==0), o_afull=(count>=AFULL_TH), o_aempty=(count<=AEMPTY_TH).
REQ-027 SHALL, when full, accept a simultaneous read and reject the write; o_count becomes SIZE_DEPTH-1 and o_overflow pulses.
REQ-028 SHALL, when empty, accept a simultaneous write and reject the read; o_count becomes 1 and o_underflow pulses.
REQ-029 SHALL, when FWFT=0, register o_data_rd with mem[rd_ptr] one cycle after an accepted read, with o_valid=1 that cycle; otherwise o_valid=0 and o_data_rd holds its value.
REQ-030 SHALL, when FWFT=1, drive o_data_rd with mem[rd_ptr] whenever o_empty=0; an accepted read exposes the next word in the following cycle; o_valid is tied to !o_empty.
REQ-031 SHALL, in FWFT mode, present a word written to an empty FIFO on o_data_rd in the cycle after the write (write-to-visible latency of 1).
REQ-032 SHALL return the old entry, never the incoming data, on a same-cycle read and write to the same address.

Reset
REQ-033 SHALL, on i_rst=1 at a clock edge, set the following, with i_rst taking priority over any concurrent request:
- wr_ptr=0, rd_ptr=0, o_count=0
- o_empty=1, o_aempty=1, o_full=0, o_afull=0
- o_valid=0, o_overflow=0, o_underflow=0
- o_data_rd=0
REQ-034 SHALL leave memory contents uninitialised on reset; data written before reset is never readable after it.
REQ-035 SHALL, on reset mid-operation, discard all pending data; the first post-reset write is the first word read.

Structure
REQ-036 SHALL place the read-mode constants (FWFT_OFF, FWFT_ON) and a count-width helper function in shared package fifo_pkg.
REQ-037 SHALL instantiate storage as sub-module smemory_sync, a single-clock memory with 1 write port and 1 read port; the read port is registered for FWFT=0 and asynchronous for FWFT=1.

Verification
REQ-038 SHALL cover fill: reset, then write 0x01..0x10 (16 words) -> o_full=1 after the 16th, o_afull=1 from count 12, o_count=16.
REQ-039 SHALL cover overflow: while full, write 0xAA -> o_overflow pulses one cycle; reading back yields 0x01..0x10 with no 0xAA.
REQ-040 SHALL cover underflow: while empty, i_rd_en=1 -> o_underflow pulses, o_valid=0, o_count stays 0.
REQ-041 SHALL cover simultaneous read+write at count 16 -> read accepted, write rejected, o_count=15; at count 0 -> write accepted, o_count=1.
REQ-042 SHALL cover wrap: run 40 continuous read+write cycles at count 8 -> output order matches input order, o_count constant at 8.
REQ-043 SHALL cover FWFT=1: write 0x5C into an empty FIFO -> o_data_rd=0x5C the next cycle without i_rd_en; then assert reset mid-stream -> o_empty=1, o_data_rd=0.
